// File: rtl/dbg_bus_master.sv
// Byte-serial debug command decoder that drives a 32-bit data bus (read/write).
// Optional macro DBG_AUTOINC_EN enables the 'N' opcode: auto-increment address by 4 and read.
module dbg_bus_master #(
    parameter logic [7:0] ACK_BYTE = 8'h4B,
    parameter logic [7:0] NAK_BYTE = 8'h3F
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [31:0] mst_address,
    output logic [31:0] mst_write_data,
    output logic [1:0]  mst_mode,
    input  logic [31:0] mst_read_data
);

    localparam logic [7:0] OP_READ  = 8'h52;
    localparam logic [7:0] OP_WRITE = 8'h57;
`ifdef DBG_AUTOINC_EN
    localparam logic [7:0] OP_NEXT  = 8'h4E;
`endif

    typedef enum logic [2:0] {IDLE, ADDR, DATA, BUS, RESP} state_t;

    state_t      state, state_nxt;
    logic [1:0]  byte_cnt;
    logic        is_write;
    logic [31:0] resp_reg;
    logic [1:0]  tx_cnt;
    logic [1:0]  tx_last;
    logic        rx_fire;
    logic        tx_fire;
    logic        is_rw_op;
    logic        is_next_op;

    assign rx_fire  = rx_valid && rx_ready;
    assign tx_fire  = tx_valid && tx_ready;
    assign is_rw_op = (rx_data == OP_READ) || (rx_data == OP_WRITE);
`ifdef DBG_AUTOINC_EN
    assign is_next_op = (rx_data == OP_NEXT);
`else
    assign is_next_op = 1'b0;
`endif

    // tx_data tracks the selected response byte even when idle; tx_valid qualifies it
    assign tx_data = resp_reg[{tx_cnt, 3'b000} +: 8];

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        rx_ready  = 1'b0;
        tx_valid  = 1'b0;
        mst_mode  = 2'b00;
        case (state)
            IDLE: begin
                rx_ready = 1'b1;
                if (rx_valid) begin
                    if (is_rw_op)        state_nxt = ADDR;
                    else if (is_next_op) state_nxt = BUS;
                    else                 state_nxt = RESP;
                end
            end
            ADDR: begin
                rx_ready = 1'b1;
                if (rx_valid && byte_cnt == 2'd3) state_nxt = is_write ? DATA : BUS;
            end
            DATA: begin
                rx_ready = 1'b1;
                if (rx_valid && byte_cnt == 2'd3) state_nxt = BUS;
            end
            BUS: begin
                mst_mode  = is_write ? 2'b10 : 2'b01;
                state_nxt = RESP;
            end
            RESP: begin
                tx_valid = 1'b1;
                if (tx_ready && tx_cnt == tx_last) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            byte_cnt       <= 2'd0;
            is_write       <= 1'b0;
            mst_address    <= 32'h0;
            mst_write_data <= 32'h0;
            resp_reg       <= 32'h0;
            tx_cnt         <= 2'd0;
            tx_last        <= 2'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (rx_fire) begin
                        byte_cnt <= 2'd0;
                        tx_cnt   <= 2'd0;
                        if (is_rw_op) begin
                            is_write <= (rx_data == OP_WRITE);
                        end else if (is_next_op) begin
                            is_write    <= 1'b0;
                            mst_address <= mst_address + 32'd4;
                        end else begin
                            resp_reg <= {24'h0, NAK_BYTE};
                            tx_last  <= 2'd0;
                        end
                    end
                end
                ADDR: begin
                    if (rx_fire) begin
                        mst_address[{byte_cnt, 3'b000} +: 8] <= rx_data;
                        byte_cnt <= byte_cnt + 2'd1;
                    end
                end
                DATA: begin
                    if (rx_fire) begin
                        mst_write_data[{byte_cnt, 3'b000} +: 8] <= rx_data;
                        byte_cnt <= byte_cnt + 2'd1;
                    end
                end
                BUS: begin
                    tx_cnt <= 2'd0;
                    if (is_write) begin
                        resp_reg <= {24'h0, ACK_BYTE};
                        tx_last  <= 2'd0;
                    end else begin
                        resp_reg <= mst_read_data;
                        tx_last  <= 2'd3;
                    end
                end
                RESP: begin
                    // return to byte 0 after the last handshake so idle output is deterministic
                    if (tx_fire) tx_cnt <= (tx_cnt == tx_last) ? 2'd0 : tx_cnt + 2'd1;
                end
                default: ;
            endcase
        end
    end

endmodule
